// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {IDLE, GRANT_D, GRANT_F, RESP} arbState_t;

  typedef enum logic {REQ_F, REQ_D} reqId_t;

  // Instruction fetches are always full-word reads.
  localparam logic [2:0] FETCH_SIZE = 3'b010;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Saturating up-counter with clear/enable and a terminal-count flag.
// It serves as both the transaction watchdog and the fetch starvation counter.
module mem_arb_watchdog #(
  parameter int CNT_WIDTH = 8,
  parameter int LIMIT     = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [CNT_WIDTH-1:0] LIMIT_C = CNT_WIDTH'(LIMIT);

  logic [CNT_WIDTH-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && (cnt_q != LIMIT_C)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc_o = (cnt_q == LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and load/store,
// with data priority, fetch anti-starvation, a hung-transaction watchdog and flush.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ifReq,
  input  logic [ADDR_WIDTH-1:0] ifAddr,
  input  logic                  ifFlush,
  output logic [DATA_WIDTH-1:0] ifRdata,
  output logic                  ifValid,
  input  logic                  dmReq,
  input  logic                  dmWe,
  input  logic [2:0]            dmSize,
  input  logic [ADDR_WIDTH-1:0] dmAddr,
  input  logic [DATA_WIDTH-1:0] dmWdata,
  output logic [DATA_WIDTH-1:0] dmRdata,
  output logic                  dmValid,
  output logic                  memReq,
  output logic                  memWe,
  output logic [2:0]            memSize,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [DATA_WIDTH-1:0] memWdata,
  input  logic [DATA_WIDTH-1:0] memRdata,
  input  logic                  memAck,
  output logic                  StallF,
  output logic                  StallM,
  output logic                  busErr
);

  arbState_t             state_q, state_d;
  logic                  memReq_q, memReq_d;
  logic                  memWe_q, memWe_d;
  logic [2:0]            memSize_q, memSize_d;
  logic [ADDR_WIDTH-1:0] memAddr_q, memAddr_d;
  logic [DATA_WIDTH-1:0] memWdata_q, memWdata_d;
  logic [DATA_WIDTH-1:0] ifRdata_q, ifRdata_d;
  logic [DATA_WIDTH-1:0] dmRdata_q, dmRdata_d;
  logic                  ifValid_q, ifValid_d;
  logic                  dmValid_q, dmValid_d;
  logic                  busErr_q, busErr_d;
  logic                  flushed_q, flushed_d;

  reqId_t winner;
  logic   grant;
  logic   in_grant;
  logic   starve_clr, starve_en, starve_tc;
  logic   wd_tc;

  assign in_grant = (state_q == GRANT_D) || (state_q == GRANT_F);

  // Watchdog terminal count marks the last GRANT cycle the memory is allowed.
  mem_arb_watchdog #(.CNT_WIDTH(CNT_WIDTH), .LIMIT(TIMEOUT_CYCLES - 1)) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr_i (!in_grant),
    .en_i  (in_grant),
    .tc_o  (wd_tc)
  );

  mem_arb_watchdog #(.CNT_WIDTH(CNT_WIDTH), .LIMIT(STARVE_LIMIT)) u_starve (
    .clk   (clk),
    .rst   (rst),
    .clr_i (starve_clr),
    .en_i  (starve_en),
    .tc_o  (starve_tc)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    memReq_d   = memReq_q;
    memWe_d    = memWe_q;
    memSize_d  = memSize_q;
    memAddr_d  = memAddr_q;
    memWdata_d = memWdata_q;
    ifRdata_d  = ifRdata_q;
    dmRdata_d  = dmRdata_q;
    ifValid_d  = 1'b0;
    dmValid_d  = 1'b0;
    busErr_d   = busErr_q;
    flushed_d  = flushed_q;
    winner     = REQ_D;
    grant      = 1'b0;
    starve_clr = 1'b0;
    starve_en  = 1'b0;

    case (state_q)
      IDLE: begin
        if (ifReq && (starve_tc || !dmReq)) begin
          winner = REQ_F;
          grant  = 1'b1;
        end else if (dmReq) begin
          winner = REQ_D;
          grant  = 1'b1;
        end
        starve_clr = !ifReq || (grant && (winner == REQ_F));
        starve_en  = grant && (winner == REQ_D) && ifReq;
        if (grant) begin
          memReq_d  = 1'b1;
          flushed_d = 1'b0;
          if (winner == REQ_F) begin
            state_d    = GRANT_F;
            memWe_d    = 1'b0;
            memSize_d  = FETCH_SIZE;
            memAddr_d  = ifAddr;
            memWdata_d = '0;
          end else begin
            state_d    = GRANT_D;
            memWe_d    = dmWe;
            memSize_d  = dmSize;
            memAddr_d  = dmAddr;
            memWdata_d = dmWdata;
          end
        end
      end
      GRANT_D, GRANT_F: begin
        if ((state_q == GRANT_F) && ifFlush) flushed_d = 1'b1;
        // An ack on the timeout cycle wins: it is a normal completion.
        if (memAck || wd_tc) begin
          memReq_d = 1'b0;
          state_d  = RESP;
          if (!memAck) busErr_d = 1'b1;
          if (state_q == GRANT_F) begin
            ifRdata_d = memAck ? memRdata : '0;
            ifValid_d = !(flushed_q || ifFlush);
          end else begin
            dmRdata_d = (memAck && !memWe_q) ? memRdata : '0;
            dmValid_d = 1'b1;
          end
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memSize_q  <= '0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      ifRdata_q  <= '0;
      dmRdata_q  <= '0;
      ifValid_q  <= 1'b0;
      dmValid_q  <= 1'b0;
      busErr_q   <= 1'b0;
      flushed_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      memReq_q   <= memReq_d;
      memWe_q    <= memWe_d;
      memSize_q  <= memSize_d;
      memAddr_q  <= memAddr_d;
      memWdata_q <= memWdata_d;
      ifRdata_q  <= ifRdata_d;
      dmRdata_q  <= dmRdata_d;
      ifValid_q  <= ifValid_d;
      dmValid_q  <= dmValid_d;
      busErr_q   <= busErr_d;
      flushed_q  <= flushed_d;
    end
  end

  assign memReq   = memReq_q;
  assign memWe    = memWe_q;
  assign memSize  = memSize_q;
  assign memAddr  = memAddr_q;
  assign memWdata = memWdata_q;
  assign ifRdata  = ifRdata_q;
  assign dmRdata  = dmRdata_q;
  assign dmValid  = dmValid_q;
  assign busErr   = busErr_q;

  // A flush arriving in the RESP cycle itself still has to kill the fetch response.
  assign ifValid  = ifValid_q & ~ifFlush;
  assign StallF   = ifReq & ~ifValid;
  assign StallM   = dmReq & ~dmValid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: cycle vectors, corner-case
// sequences and randomized transactions against a transaction-level model.
module tb_mem_port_arbiter;

  localparam int STARVE_LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ifReq = 1'b0, ifFlush = 1'b0, ifValid;
  logic [31:0] ifAddr = '0, ifRdata;
  logic        dmReq = 1'b0, dmWe = 1'b0, dmValid;
  logic [2:0]  dmSize = '0;
  logic [31:0] dmAddr = '0, dmWdata = '0, dmRdata;
  logic        memReq, memWe, memAck = 1'b0;
  logic [2:0]  memSize;
  logic [31:0] memAddr, memWdata, memRdata = '0;
  logic        StallF, StallM, busErr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .ifReq(ifReq), .ifAddr(ifAddr), .ifFlush(ifFlush), .ifRdata(ifRdata), .ifValid(ifValid),
    .dmReq(dmReq), .dmWe(dmWe), .dmSize(dmSize), .dmAddr(dmAddr), .dmWdata(dmWdata),
    .dmRdata(dmRdata), .dmValid(dmValid),
    .memReq(memReq), .memWe(memWe), .memSize(memSize), .memAddr(memAddr), .memWdata(memWdata),
    .memRdata(memRdata), .memAck(memAck),
    .StallF(StallF), .StallM(StallM), .busErr(busErr)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One record per clock cycle: inputs for the cycle and the outputs expected in it.
  typedef struct {
    logic        ifr, fl, dmr, ack;
    logic [31:0] rdin;
    logic        e_req, e_we;
    logic [31:0] e_addr;
    logic [2:0]  e_size;
    logic [31:0] e_wd;
    logic        e_ifv, e_dmv;
    logic [31:0] e_rd;
    logic        e_stf, e_stm;
  } vec_t;

  function automatic vec_t mk(input int ifr, input int fl, input int dmr, input int ack,
                              input int rdin, input int e_req, input int e_we, input int e_addr,
                              input int e_size, input int e_wd, input int e_ifv, input int e_dmv,
                              input int e_rd, input int e_stf, input int e_stm);
    vec_t v;
    v.ifr = ifr[0];     v.fl = fl[0];       v.dmr = dmr[0];     v.ack = ack[0];
    v.rdin = 32'(rdin); v.e_req = e_req[0]; v.e_we = e_we[0];   v.e_addr = 32'(e_addr);
    v.e_size = e_size[2:0]; v.e_wd = 32'(e_wd); v.e_ifv = e_ifv[0]; v.e_dmv = e_dmv[0];
    v.e_rd = 32'(e_rd); v.e_stf = e_stf[0]; v.e_stm = e_stm[0];
    return v;
  endfunction

  vec_t vq[$];

  logic        s_ok, s_we;
  logic [31:0] s_addr, s_wd;
  logic [2:0]  s_size;

  // Waits for memReq, acks it after 'delay' extra cycles, returns in the RESP cycle.
  task automatic serve(input int delay, input logic [31:0] rd, output logic ok, output logic we,
                       output logic [31:0] addr, output logic [2:0] size, output logic [31:0] wd);
    int n = 0;
    ok = 1'b1; we = 1'b0; addr = '0; size = '0; wd = '0;
    @(negedge clk);
    while (!memReq && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!memReq) begin
      ok = 1'b0;
      return;
    end
    we = memWe; addr = memAddr; size = memSize; wd = memWdata;
    repeat (delay) @(negedge clk);
    memAck = 1'b1;
    memRdata = rd;
    @(negedge clk);
    memAck = 1'b0;
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    @(negedge clk);
    while (!memReq && n < 20) begin
      @(negedge clk);
      n++;
    end
    check1(name, memReq, 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, bad=%0d", bad);
    $fatal(1, "global timeout");
  end

  initial begin
    int          n, starve;
    logic        exp_f, pf, pd, wed, win_f;
    logic [31:0] af, ad, wdd, rd;
    logic [2:0]  szd;

    // Cycle vectors. Fetch address 0x100; data side stores 0x55 to 0x2000 with size 0.
    vq.push_back(mk(1,0,0,0,0,           0,0,0,0,0,          0,0,0,           1,0));
    vq.push_back(mk(1,0,0,0,0,           1,0,'h100,2,0,      0,0,0,           1,0));
    vq.push_back(mk(1,0,0,1,'hDEADBEEF,  1,0,'h100,2,0,      0,0,0,           1,0));
    vq.push_back(mk(1,0,0,0,0,           0,0,0,0,0,          1,0,'hDEADBEEF,  0,0));
    vq.push_back(mk(0,0,0,0,0,           0,0,0,0,0,          0,0,0,           0,0));
    vq.push_back(mk(1,0,1,0,0,           0,0,0,0,0,          0,0,0,           1,1));
    vq.push_back(mk(1,0,1,0,0,           1,1,'h2000,0,'h55,  0,0,0,           1,1));
    vq.push_back(mk(1,0,1,1,'h12345678,  1,1,'h2000,0,'h55,  0,0,0,           1,1));
    vq.push_back(mk(1,0,1,0,0,           0,0,0,0,0,          0,1,0,           1,0));
    vq.push_back(mk(1,0,0,0,0,           0,0,0,0,0,          0,0,0,           1,0));
    vq.push_back(mk(1,0,0,0,0,           1,0,'h100,2,0,      0,0,0,           1,0));
    vq.push_back(mk(1,0,0,1,'hCAFEF00D,  1,0,'h100,2,0,      0,0,0,           1,0));
    vq.push_back(mk(1,0,0,0,0,           0,0,0,0,0,          1,0,'hCAFEF00D,  0,0));
    vq.push_back(mk(0,0,0,0,0,           0,0,0,0,0,          0,0,0,           0,0));
    vq.push_back(mk(1,0,0,0,0,           0,0,0,0,0,          0,0,0,           1,0));
    vq.push_back(mk(1,1,0,0,0,           1,0,'h100,2,0,      0,0,0,           1,0));
    vq.push_back(mk(1,0,0,0,0,           1,0,'h100,2,0,      0,0,0,           1,0));
    vq.push_back(mk(1,0,0,1,'h11111111,  1,0,'h100,2,0,      0,0,0,           1,0));
    vq.push_back(mk(1,0,0,0,0,           0,0,0,0,0,          0,0,0,           1,0));
    vq.push_back(mk(1,0,0,0,0,           0,0,0,0,0,          0,0,0,           1,0));
    vq.push_back(mk(1,0,0,0,0,           1,0,'h100,2,0,      0,0,0,           1,0));
    vq.push_back(mk(1,0,0,1,'h22222222,  1,0,'h100,2,0,      0,0,0,           1,0));
    vq.push_back(mk(1,0,0,0,0,           0,0,0,0,0,          1,0,'h22222222,  0,0));
    vq.push_back(mk(0,0,0,0,0,           0,0,0,0,0,          0,0,0,           0,0));
    vq.push_back(mk(1,0,0,0,0,           0,0,0,0,0,          0,0,0,           1,0));
    vq.push_back(mk(1,0,0,1,'h33333333,  1,0,'h100,2,0,      0,0,0,           1,0));
    vq.push_back(mk(1,1,0,0,0,           0,0,0,0,0,          0,0,0,           1,0));
    vq.push_back(mk(0,0,0,1,'h44444444,  0,0,0,0,0,          0,0,0,           0,0));
    vq.push_back(mk(0,0,0,0,0,           0,0,0,0,0,          0,0,0,           0,0));

    // Reset state.
    repeat (2) @(negedge clk);
    check1("rst_memReq", memReq, 1'b0);
    check1("rst_ifValid", ifValid, 1'b0);
    check1("rst_dmValid", dmValid, 1'b0);
    check1("rst_busErr", busErr, 1'b0);
    check32("rst_memAddr", memAddr, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    ifAddr = 32'h100; dmAddr = 32'h2000; dmWdata = 32'h55; dmWe = 1'b1; dmSize = 3'b000;
    foreach (vq[i]) begin
      ifReq = vq[i].ifr; ifFlush = vq[i].fl; dmReq = vq[i].dmr;
      memAck = vq[i].ack; memRdata = vq[i].rdin;
      #1;
      check1($sformatf("row%0d memReq", i), memReq, vq[i].e_req);
      if (vq[i].e_req) begin
        check32($sformatf("row%0d memAddr", i), memAddr, vq[i].e_addr);
        check1($sformatf("row%0d memWe", i), memWe, vq[i].e_we);
        check32($sformatf("row%0d memSize", i), {29'd0, memSize}, {29'd0, vq[i].e_size});
        if (vq[i].e_we) check32($sformatf("row%0d memWdata", i), memWdata, vq[i].e_wd);
      end
      check1($sformatf("row%0d ifValid", i), ifValid, vq[i].e_ifv);
      check1($sformatf("row%0d dmValid", i), dmValid, vq[i].e_dmv);
      if (vq[i].e_ifv) check32($sformatf("row%0d ifRdata", i), ifRdata, vq[i].e_rd);
      if (vq[i].e_dmv) check32($sformatf("row%0d dmRdata", i), dmRdata, vq[i].e_rd);
      check1($sformatf("row%0d StallF", i), StallF, vq[i].e_stf);
      check1($sformatf("row%0d StallM", i), StallM, vq[i].e_stm);
      @(negedge clk);
    end
    ifReq = 1'b0; ifFlush = 1'b0; dmReq = 1'b0; memAck = 1'b0;

    // Starvation: both held; grants must run D D D D F D D D D F.
    ifReq = 1'b1; dmReq = 1'b1; dmWe = 1'b1;
    for (int g = 0; g < 10; g++) begin
      exp_f = (g == 4) || (g == 9);
      serve(0, 32'(g), s_ok, s_we, s_addr, s_size, s_wd);
      check1($sformatf("starve_served%0d", g), s_ok, 1'b1);
      check1($sformatf("starve_we%0d", g), s_we, !exp_f);
      check1($sformatf("starve_ifv%0d", g), ifValid, exp_f);
      check1($sformatf("starve_dmv%0d", g), dmValid, !exp_f);
    end
    ifReq = 1'b0; dmReq = 1'b0;
    repeat (2) @(negedge clk);

    // Watchdog: a load that is never acknowledged.
    dmWe = 1'b0; dmAddr = 32'h3000; dmReq = 1'b1; memRdata = 32'hBAD0BAD0;
    wait_req("timeout_start");
    n = 0;
    while (memReq && n < 400) begin
      n++;
      @(negedge clk);
    end
    check32("timeout_len", 32'(n), 32'd255);
    check1("timeout_dmValid", dmValid, 1'b1);
    check32("timeout_dmRdata", dmRdata, 32'h0);
    check1("timeout_busErr", busErr, 1'b1);
    dmReq = 1'b0;
    repeat (5) @(negedge clk);
    check1("busErr_sticky", busErr, 1'b1);
    ifReq = 1'b1; ifAddr = 32'h140;
    serve(1, 32'h5A5A5A5A, s_ok, s_we, s_addr, s_size, s_wd);
    check1("post_to_served", s_ok, 1'b1);
    check1("post_to_ifValid", ifValid, 1'b1);
    check32("post_to_ifRdata", ifRdata, 32'h5A5A5A5A);
    check1("post_to_busErr", busErr, 1'b1);
    ifReq = 1'b0;
    @(negedge clk);

    // Reset while a fetch is outstanding.
    ifReq = 1'b1;
    wait_req("rst_pre_req");
    rst = 1'b1;
    @(negedge clk);
    check1("rst_mid_memReq", memReq, 1'b0);
    check1("rst_mid_busErr", busErr, 1'b0);
    check1("rst_mid_ifValid", ifValid, 1'b0);
    check1("rst_mid_dmValid", dmValid, 1'b0);
    rst = 1'b0;
    serve(0, 32'hABCD1234, s_ok, s_we, s_addr, s_size, s_wd);
    check1("rst_after_served", s_ok, 1'b1);
    check1("rst_after_ifValid", ifValid, 1'b1);
    check32("rst_after_ifRdata", ifRdata, 32'hABCD1234);
    ifReq = 1'b0;
    @(negedge clk);

    // Ack on the last allowed GRANT cycle is a normal completion.
    dmWe = 1'b0; dmAddr = 32'h3004; dmReq = 1'b1; memRdata = '0;
    wait_req("edge_start");
    n = 1;
    while (n < 255) begin
      @(negedge clk);
      n++;
    end
    check1("edge_memReq", memReq, 1'b1);
    memAck = 1'b1; memRdata = 32'h77;
    @(negedge clk);
    memAck = 1'b0;
    check1("edge_dmValid", dmValid, 1'b1);
    check32("edge_dmRdata", dmRdata, 32'h77);
    check1("edge_busErr", busErr, 1'b0);
    dmReq = 1'b0;
    repeat (2) @(negedge clk);

    // Random transactions against a transaction-level model of arbitration.
    starve = 0; pf = 1'b0; pd = 1'b0;
    af = '0; ad = '0; wdd = '0; wed = 1'b0; szd = '0;
    for (int r = 0; r < 60; r++) begin
      if (!pf && $urandom_range(1, 0) == 1) begin pf = 1'b1; af = $urandom; end
      if (!pd && $urandom_range(1, 0) == 1) begin
        pd = 1'b1; ad = $urandom; wdd = $urandom;
        wed = 1'($urandom_range(1, 0)); szd = 3'($urandom_range(7, 0));
      end
      if (!pf && !pd) begin pf = 1'b1; af = $urandom; end
      ifReq = pf; ifAddr = af;
      dmReq = pd; dmAddr = ad; dmWe = wed; dmSize = szd; dmWdata = wdd;
      win_f = pf && ((starve == STARVE_LIMIT) || !pd);
      if (win_f)     starve = 0;
      else if (pf)   starve = (starve < STARVE_LIMIT) ? starve + 1 : starve;
      else           starve = 0;
      rd = $urandom;
      serve(int'($urandom_range(3, 0)), rd, s_ok, s_we, s_addr, s_size, s_wd);
      check1($sformatf("rnd%0d served", r), s_ok, 1'b1);
      check32($sformatf("rnd%0d addr", r), s_addr, win_f ? af : ad);
      check1($sformatf("rnd%0d we", r), s_we, win_f ? 1'b0 : wed);
      check32($sformatf("rnd%0d size", r), {29'd0, s_size}, {29'd0, win_f ? 3'b010 : szd});
      if (!win_f && wed) check32($sformatf("rnd%0d wdata", r), s_wd, wdd);
      check1($sformatf("rnd%0d ifValid", r), ifValid, win_f);
      check1($sformatf("rnd%0d dmValid", r), dmValid, !win_f);
      if (win_f) check32($sformatf("rnd%0d ifRdata", r), ifRdata, rd);
      else       check32($sformatf("rnd%0d dmRdata", r), dmRdata, wed ? 32'h0 : rd);
      if (win_f) pf = 1'b0;
      else       pd = 1'b0;
    end
    ifReq = 1'b0; dmReq = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
